// File: rtl/draw_text_layer_if.sv
// VGA timing bundle shared by the text overlay and its neighbours in the video chain.
// "in" is the consumer view, "out" is the producer view.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;

    modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
    modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/draw_text_layer.sv
// Text-window overlay: addresses an external character buffer / font ROM and composites
// glyph pixels over the upstream video with a 4-clock pipeline and a blinking cursor.
module draw_text_layer #(
    parameter int FONT_W       = 8,
    parameter int FONT_H       = 16,
    parameter int COLS         = 16,
    parameter int ROWS         = 16,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30,
    parameter int RGB_B        = 12
) (
    input  logic                                  clk,
    input  logic                                  rst,
    vga_if.in                                     vga_in,
    input  logic [RGB_B-1:0]                      rgb_i,
    vga_if.out                                    vga_out,
    output logic [RGB_B-1:0]                      rgb_o,
    input  logic [10:0]                           x_pos,
    input  logic [10:0]                           y_pos,
    input  logic [RGB_B-1:0]                      fg_color,
    input  logic [RGB_B-1:0]                      bg_color,
    input  logic                                  bg_en,
    input  logic                                  cursor_en,
    input  logic [$clog2(ROWS)+$clog2(COLS)-1:0]  cursor_xy,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0]  char_xy,
    output logic [$clog2(FONT_H)-1:0]             char_line,
    input  logic [0:FONT_W-1]                     char_pixels
);

    localparam int FW_L  = $clog2(FONT_W);
    localparam int FH_L  = $clog2(FONT_H);
    localparam int COL_L = $clog2(COLS);
    localparam int ROW_L = $clog2(ROWS);
    localparam int XY_W  = ROW_L + COL_L;
    localparam int TIM_W = 26;
    localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [31:0] WIN_W = 32'((FONT_W * COLS) << SCALE_LOG2);
    localparam logic [31:0] WIN_H = 32'((FONT_H * ROWS) << SCALE_LOG2);

    // ---------------- stage 0: window-relative coordinates ----------------
    logic [10:0]      w_dx;
    logic [10:0]      w_dy;
    logic             w_in_win;
    logic [COL_L-1:0] w_col;
    logic [ROW_L-1:0] w_row;
    logic [FW_L-1:0]  w_px;
    logic [FH_L-1:0]  w_line;
    logic [XY_W-1:0]  w_xy;
    logic             w_hit;
    logic [TIM_W-1:0] w_tim_in;

    assign w_dx = vga_in.hcount - x_pos;
    assign w_dy = vga_in.vcount - y_pos;

    assign w_in_win = (vga_in.hcount >= x_pos) && (vga_in.vcount >= y_pos) &&
                      ({21'd0, w_dx} < WIN_W) && ({21'd0, w_dy} < WIN_H);

    // Unscaling and the col/px split are pure bit-slices; the whole text field
    // (including magnification) must therefore fit inside the 11-bit counters.
    assign w_px   = w_dx[SCALE_LOG2 +: FW_L];
    assign w_col  = w_dx[SCALE_LOG2 + FW_L +: COL_L];
    assign w_line = w_dy[SCALE_LOG2 +: FH_L];
    assign w_row  = w_dy[SCALE_LOG2 + FH_L +: ROW_L];
    assign w_xy   = {w_row, w_col};
    assign w_hit  = (cursor_xy == w_xy);

    assign w_tim_in = {vga_in.hcount, vga_in.vcount, vga_in.hblnk,
                       vga_in.vblnk, vga_in.hsync, vga_in.vsync};

    // ---------------- stages 1..3: side-band pipeline ----------------
    // Index 0 holds stage 1, index 2 holds stage 3.
    logic [2:0][FW_L-1:0]  r_px;
    logic [2:0]            r_win;
    logic [2:0]            r_hit;
    logic [2:0][TIM_W-1:0] r_tim;
    logic [2:0][RGB_B-1:0] r_rgb;

    // NOTE: every pipeline register is reset so a mid-frame reset can never leak
    // a half-processed pixel; non-blocking assignments keep the stages moving in lockstep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_xy   <= '0;
            char_line <= '0;
            r_px      <= '0;
            r_win     <= '0;
            r_hit     <= '0;
            r_tim     <= '0;
            r_rgb     <= '0;
        end else begin
            char_xy   <= w_xy;
            char_line <= w_line;
            r_px      <= {r_px[1:0],  w_px};
            r_win     <= {r_win[1:0], w_in_win};
            r_hit     <= {r_hit[1:0], w_hit};
            r_tim     <= {r_tim[1:0], w_tim_in};
            r_rgb     <= {r_rgb[1:0], rgb_i};
        end
    end

    // ---------------- cursor blink, one tick per vblank entry ----------------
    logic            r_vblnk_d;
    logic [BC_W-1:0] r_blink_cnt;
    logic            r_blink_on;
    logic            w_frame_tick;

    assign w_frame_tick = vga_in.vblnk & ~r_vblnk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vblnk_d   <= 1'b0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else begin
            r_vblnk_d <= vga_in.vblnk;
            if (w_frame_tick) begin
                if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 3: compose and register the output ----------------
    logic w_pix;
    logic w_inv;
    logic w_glyph;

    assign w_pix   = char_pixels[r_px[2]];
    assign w_inv   = cursor_en & r_hit[2] & r_blink_on;
    assign w_glyph = w_pix ^ w_inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_o <= '0;
            {vga_out.hcount, vga_out.vcount, vga_out.hblnk,
             vga_out.vblnk, vga_out.hsync, vga_out.vsync} <= '0;
        end else begin
            if (r_win[2] && w_glyph) begin
                rgb_o <= fg_color;
            end else if (r_win[2] && (bg_en || w_inv)) begin
                rgb_o <= bg_color;
            end else begin
                rgb_o <= r_rgb[2];
            end
            {vga_out.hcount, vga_out.vcount, vga_out.hblnk,
             vga_out.vblnk, vga_out.hsync, vga_out.vsync} <= r_tim[2];
        end
    end

endmodule

// File: doc/draw_text_layer.md
DRAW_TEXT_LAYER -- requirements
Module: draw_text_layer

Interface
REQ-001 SHALL have parameter FONT_W, default 8, glyph width in pixels (power of 2, 4..16).
REQ-002 SHALL have parameter FONT_H, default 16, glyph height in lines (power of 2, 8..32).
REQ-003 SHALL have parameter COLS, default 16, characters per line (power of 2).
REQ-004 SHALL have parameter ROWS, default 16, number of text lines (power of 2).
REQ-005 SHALL have parameter SCALE_LOG2, default 0, pixel magnification 2^SCALE_LOG2 (0..2).
REQ-006 SHALL have parameter BLINK_FRAMES, default 30, frames per cursor blink half-period (>=1).
REQ-007 clk  in  1  pixel clock; all state changes on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 vga_in  vga_if.in  -  timing in (hcount/vcount 11b, hblnk, vblnk, hsync, vsync).
REQ-010 rgb_i  in  RGB_B  background pixel from upstream, aligned with vga_in.
REQ-011 vga_out  vga_if.out  -  timing out, delayed 4 clocks.
REQ-012 rgb_o  out  RGB_B  composited pixel, aligned with vga_out.
REQ-013 x_pos, y_pos  in  11 each  runtime top-left corner of text window.
REQ-014 fg_color, bg_color  in  RGB_B each  glyph colour and cell background colour.
REQ-015 bg_en  in  1  1 = opaque cells (bg_color), 0 = transparent (rgb_i shows through).
REQ-016 cursor_en  in  1  enables blinking cursor.
REQ-017 cursor_xy  in  log2(ROWS)+log2(COLS)  cursor cell, {row, col}.
REQ-018 char_xy  out  log2(ROWS)+log2(COLS)  character-buffer address, {row, col}.
REQ-019 char_line  out  log2(FONT_H)  glyph line index for font ROM.
REQ-020 char_pixels  in  FONT_W  [0:FONT_W-1] glyph line, bit 0 leftmost, valid 2 clocks after char_xy/char_line.

Function
REQ-021 Stage 0 (comb from vga_in): dx = hcount-x_pos, dy = vcount-y_pos, both 11b modulo; in_win = hcount>=x_pos and vcount>=y_pos and dx < FONT_W*COLS<<SCALE_LOG2 and dy < FONT_H*ROWS<<SCALE_LOG2.
REQ-022 Unscaled coords: ux = dx>>SCALE_LOG2, uy = dy>>SCALE_LOG2; col = ux/FONT_W, row = uy/FONT_H, px = ux mod FONT_W, line = uy mod FONT_H.
REQ-023 Stage 1 register: char_xy <= {row,col}, char_line <= line; px, in_win, cursor_hit = (cursor_xy=={row,col}) carried through a 3-deep pipeline alongside.
REQ-024 Out of window, char_xy and char_line SHALL still register the truncated computed values (don't-care to ROM); in_win=0 masks them.
REQ-025 Stage 3 (comb): pix = char_pixels[px]; inv = cursor_en & cursor_hit & blink_on; glyph = pix XOR inv.
REQ-026 rgb_o <= fg_color when in_win & glyph; bg_color when in_win & !glyph & (bg_en | inv); else rgb_i delayed 3 clocks.
REQ-027 vga_out fields and rgb_o SHALL be registered; total latency vga_in -> vga_out exactly 4 clocks, no bubbles, one pixel per clock.
REQ-028 Frame tick = rising edge of vga_in.vblnk (registered previous value).
REQ-029 Blink counter (width clog2(BLINK_FRAMES)) increments on frame tick; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_on.
REQ-030 cursor_en=0 SHALL not stop the blink counter; cursor shows with current phase when re-enabled.
REQ-031 x_pos/y_pos/colours/bg_en/cursor inputs sampled at stage 0/3 as used; mid-frame changes take effect on the next pixel with no glitch protection (caller updates in vblank).
REQ-032 Window exceeding 2048 wraps nothing: in_win compares are unsigned 11b; pixels beyond hcount 2047 never drawn.

Reset
REQ-033 On rst=1, asynchronously: all vga_out fields 0, rgb_o 0, char_xy 0, char_line 0, pipeline registers 0, blink counter 0, blink_on 0, vblnk history 0.
REQ-034 First valid rgb_o SHALL appear 4 clocks after rst deasserts with valid vga_in; reset mid-frame restarts pipeline with no stale pixels emitted.

Verification
REQ-035 Defaults, x_pos=100,y_pos=50, ROM returns 8'b1000_0001 for all lines, bg_en=0 -> pixels (100,50),(107,50) = fg_color, (101..106,50) = rgb_i, (228,50) = rgb_i.
REQ-036 bg_en=1, bg_color=12'h00F, same glyph -> (101,50)=12'h00F, (99,50)=rgb_i.
REQ-037 SCALE_LOG2=1, x_pos=0,y_pos=0 -> hcount 0..1 map to px 0, hcount 16 gives char_xy col 1; window ends at hcount 255.
REQ-038 BLINK_FRAMES=2, cursor_xy={4'd0,4'd2}, cursor_en=1: blink_on toggles every 2 vblnk rising edges; during on phase cell col 2 shows inverted colours, col 3 unaffected.
REQ-039 Timing check: hsync pulse on vga_in at clock N appears on vga_out at clock N+4; char_xy at N+1; rgb_o uses char_pixels sampled at N+3.
REQ-040 Assert rst for 1 clock mid-line -> all outputs 0 immediately, blink_on 0, normal output resumes 4 clocks after release.
